// File: rtl/vrf_addr_gen.sv
// vrf_addr_gen: per-lane VRF address generator. Walks a register group element
// by element (SEW 8/16/32) and issues one registered word address per accepted
// beat over a valid/ready handshake.
// Optional feature macro: VRF_ADDR_DOWN_EN enables descending traversal and
// slide subtraction; without it up_down_i is ignored and runs are ascending.
module vrf_addr_gen #(
  parameter int unsigned MEM_DEPTH         = 512,
  parameter int unsigned VREG_LOC_PER_LANE = 8,
  parameter int unsigned MAX_GROUP         = 8,
  parameter int unsigned AW                = $clog2(MEM_DEPTH),
  parameter int unsigned CW                = $clog2(MAX_GROUP*VREG_LOC_PER_LANE*4)+1,
  parameter int unsigned GW                = $clog2(MAX_GROUP)+1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [MAX_GROUP*AW-1:0] base_addr_i,
  input  logic [GW-1:0]           group_size_i,
  input  logic [AW-1:0]           slide_offset_i,
  input  logic                    up_down_i,
  input  logic [1:0]              sew_i,
  input  logic [CW-1:0]           el_count_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [AW-1:0]           addr_o,
  output logic [1:0]              sub_sel_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int unsigned SW = $clog2(VREG_LOC_PER_LANE*4);
  localparam int unsigned RW = (MAX_GROUP > 1) ? $clog2(MAX_GROUP) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] base_q [MAX_GROUP];
  logic [AW-1:0] base_d [MAX_GROUP];
  logic [1:0]    sew_q, sew_d;
  logic [SW-1:0] lim_q, lim_d;
  logic [SW-1:0] s_q, s_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    sub_sel_q, sub_sel_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef VRF_ADDR_DOWN_EN
  logic          dir_q, dir_d;
`else
  logic          unused_up_down;
  assign unused_up_down = up_down_i;
`endif

  logic [SW-1:0] lim_in;
  logic [GW-1:0] gsz_in;
  logic [CW-1:0] cap_in;
  logic [CW-1:0] n_in;
  logic [1:0]    shift;
  logic          load;

  // Decode the run length requested at start: capped by the group capacity.
  always_comb begin
    case (sew_i)
      2'b00:   lim_in = SW'(VREG_LOC_PER_LANE*4-1);
      2'b01:   lim_in = SW'(VREG_LOC_PER_LANE*2-1);
      default: lim_in = SW'(VREG_LOC_PER_LANE-1);
    endcase
    gsz_in = (group_size_i > GW'(MAX_GROUP)) ? GW'(MAX_GROUP) : group_size_i;
    cap_in = CW'(gsz_in) * (CW'(lim_in) + CW'(1));
    if (sew_i == 2'b11 || gsz_in == '0) begin
      n_in = '0;
    end else begin
      n_in = (el_count_i < cap_in) ? el_count_i : cap_in;
    end
  end

  // Next-state logic. The output registers are loaded with the address of the
  // position the counters move to, so addr_o is registered, not decoded.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    sew_d     = sew_q;
    lim_d     = lim_q;
    s_d       = s_q;
    r_d       = r_q;
    rem_d     = rem_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    sub_sel_d = sub_sel_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 2'd0;
`ifdef VRF_ADDR_DOWN_EN
    dir_d     = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          for (int unsigned i = 0; i < MAX_GROUP; i++) begin
            base_d[i] = base_addr_i[i*AW +: AW];
          end
          sew_d = sew_i;
          lim_d = lim_in;
`ifdef VRF_ADDR_DOWN_EN
          dir_d = up_down_i;
          if (!up_down_i) begin
            base_d[0] = base_addr_i[AW-1:0] - slide_offset_i;
            s_d       = lim_in;
            r_d       = RW'(gsz_in - GW'(1));
          end else
`endif
          begin
            base_d[0] = base_addr_i[AW-1:0] + slide_offset_i;
            s_d       = '0;
            r_d       = '0;
          end
          rem_d = n_in;
          if (n_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            load    = 1'b1;
          end
        end
      end
      default: begin
        if (valid_q && ready_i) begin
          if (last_q) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            last_d    = 1'b0;
            addr_d    = '0;
            sub_sel_d = '0;
            done_d    = 1'b1;
          end else begin
            rem_d = rem_q - CW'(1);
            load  = 1'b1;
`ifdef VRF_ADDR_DOWN_EN
            if (!dir_q) begin
              if (s_q == '0) begin
                s_d = lim_q;
                r_d = r_q - RW'(1);
              end else begin
                s_d = s_q - SW'(1);
              end
            end else
`endif
            begin
              if (s_q == lim_q) begin
                s_d = '0;
                r_d = r_q + RW'(1);
              end else begin
                s_d = s_q + SW'(1);
              end
            end
          end
        end
      end
    endcase

    if (load) begin
      case (sew_d)
        2'b00:   shift = 2'd2;
        2'b01:   shift = 2'd1;
        default: shift = 2'd0;
      endcase
      addr_d = base_d[r_d] + AW'(s_d >> shift);
      case (sew_d)
        2'b00:   sub_sel_d = s_d[1:0];
        2'b01:   sub_sel_d = {s_d[0], 1'b0};
        default: sub_sel_d = 2'b00;
      endcase
      last_d = (rem_d == CW'(1));
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      for (int unsigned i = 0; i < MAX_GROUP; i++) begin
        base_q[i] <= '0;
      end
      sew_q     <= '0;
      lim_q     <= '0;
      s_q       <= '0;
      r_q       <= '0;
      rem_q     <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      sub_sel_q <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef VRF_ADDR_DOWN_EN
      dir_q     <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      sew_q     <= sew_d;
      lim_q     <= lim_d;
      s_q       <= s_d;
      r_q       <= r_d;
      rem_q     <= rem_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      sub_sel_q <= sub_sel_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef VRF_ADDR_DOWN_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign valid_o   = valid_q;
  assign addr_o    = addr_q;
  assign sub_sel_o = sub_sel_q;
  assign last_o    = last_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_vrf_addr_gen.sv
// tb_vrf_addr_gen: directed vector table, hand-written corner sequences and
// randomized runs against a behavioural model of the address walk.
module tb_vrf_addr_gen;
  localparam int AW = 9;
  localparam int GW = 4;
  localparam int CW = 9;
  localparam int MG = 8;

  logic            clk = 1'b0;
  logic            rst_i, start_i, up_down_i, ready_i;
  logic [MG*AW-1:0] base_addr_i;
  logic [GW-1:0]   group_size_i;
  logic [AW-1:0]   slide_offset_i;
  logic [1:0]      sew_i;
  logic [CW-1:0]   el_count_i;
  logic            valid_o, last_o, busy_o, done_o;
  logic [AW-1:0]   addr_o;
  logic [1:0]      sub_sel_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int sew; int gs; int slide; int up; int elc;
    logic [MG*AW-1:0] bases;
  } cfg_t;

  typedef struct {
    cfg_t c; int mode;
    int exp_beats; int exp_first_addr; int exp_first_sub; int exp_last_addr;
  } vec_t;

  vrf_addr_gen #(.MEM_DEPTH(512), .VREG_LOC_PER_LANE(8), .MAX_GROUP(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .group_size_i(group_size_i), .slide_offset_i(slide_offset_i),
    .up_down_i(up_down_i), .sew_i(sew_i), .el_count_i(el_count_i),
    .ready_i(ready_i), .valid_o(valid_o), .addr_o(addr_o),
    .sub_sel_o(sub_sel_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cfg_t mkcfg(input int sew, input int gs, input int b0, input int b1,
                                 input int slide, input int up, input int elc);
    cfg_t c;
    for (int i = 0; i < MG; i++) c.bases[i*AW +: AW] = AW'(i*61 + 7);
    c.bases[0 +: AW]  = AW'(b0);
    c.bases[AW +: AW] = AW'(b1);
    c.sew = sew; c.gs = gs; c.slide = slide; c.up = up; c.elc = elc;
    return c;
  endfunction

  function automatic vec_t mkvec(input cfg_t c, input int mode, input int nb,
                                 input int fa, input int fs, input int la);
    vec_t v;
    v.c = c; v.mode = mode; v.exp_beats = nb;
    v.exp_first_addr = fa; v.exp_first_sub = fs; v.exp_last_addr = la;
    return v;
  endfunction

  // Model: number of beats in a run.
  function automatic int model_n(input cfg_t c);
    int per, cap;
    if (c.sew == 3 || c.gs == 0) return 0;
    per = (c.sew == 0) ? 32 : (c.sew == 1) ? 16 : 8;
    cap = c.gs * per;
    return (c.elc < cap) ? c.elc : cap;
  endfunction

  // Model: address and sub-select of beat i, from element index arithmetic.
  function automatic void model_beat(input cfg_t c, input int i, output int addr, output int sub);
    int per, k, r, s, b;
    bit up;
    per = (c.sew == 0) ? 32 : (c.sew == 1) ? 16 : 8;
    k   = (c.sew == 0) ? 4 : (c.sew == 1) ? 2 : 1;
    up  = (c.up != 0);
`ifndef VRF_ADDR_DOWN_EN
    up = 1'b1;
`endif
    if (up) begin
      r = i / per;
      s = i % per;
    end else begin
      r = c.gs - 1 - i / per;
      s = per - 1 - i % per;
    end
    b = int'(c.bases[r*AW +: AW]);
    if (r == 0) b = up ? b + c.slide : b - c.slide;
    addr = (b + s / k) & 511;
    sub  = (c.sew == 0) ? s % 4 : (c.sew == 1) ? (s % 2) * 2 : 0;
  endfunction

  // mode 0: ready always 1; 1: random ready; 2: stall 3 cycles on the third
  // beat; 3: ready 1 with a spurious start and altered bases mid-run.
  task automatic do_run(input cfg_t c, input int mode,
                        output int beats, output int fa, output int fs, output int la);
    int n, cyc, stall, ea, es;
    bit rdy, prev_hold;
    logic [12:0] held;
    n = model_n(c);
    base_addr_i = c.bases; group_size_i = GW'(c.gs); slide_offset_i = AW'(c.slide);
    up_down_i = (c.up != 0); sew_i = 2'(c.sew); el_count_i = CW'(c.elc);
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    beats = 0; fa = -1; fs = -1; la = -1; stall = 0; prev_hold = 1'b0; held = '0;
    if (n == 0) begin
      check("zero_done", done_o, 1);
      check("zero_valid", valid_o, 0);
      check("zero_busy", busy_o, 0);
      @(posedge clk); #1;
      check("zero_done_drop", done_o, 0);
      check("zero_valid2", valid_o, 0);
      return;
    end
    check("busy_t1", busy_o, 1);
    check("valid_t1", valid_o, 1);
    for (cyc = 0; cyc < 4000 && beats < n; cyc++) begin
      if (prev_hold) check("hold_stable", {valid_o, addr_o, sub_sel_o, last_o}, held);
      if (mode == 3) begin
        start_i = (beats == 1);
        base_addr_i = (beats == 1) ? ~c.bases : c.bases;
      end
      if (!valid_o) begin
        check("valid_run", valid_o, 1);
        prev_hold = 1'b0;
      end else begin
        case (mode)
          1: rdy = ($urandom_range(0, 3) != 0);
          2: rdy = !(beats == 2 && stall < 3);
          default: rdy = 1'b1;
        endcase
        if (!rdy) stall++;
        ready_i = rdy;
        if (rdy) begin
          model_beat(c, beats, ea, es);
          check("addr", addr_o, ea);
          check("sub_sel", sub_sel_o, es);
          check("last", last_o, (beats == n - 1));
          check("done_mid", done_o, 0);
          if (beats == 0) begin fa = int'(addr_o); fs = int'(sub_sel_o); end
          la = int'(addr_o);
          beats++;
        end
        prev_hold = !rdy;
        held = {valid_o, addr_o, sub_sel_o, last_o};
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    check("beats_in_bound", beats, n);
    if (mode == 0 || mode == 3) check("run_cycles", cyc, n);
    if (mode == 2) check("stall_cycles", stall, 3);
    check("done_pulse", done_o, 1);
    check("valid_end", valid_o, 0);
    check("busy_end", busy_o, 0);
    @(posedge clk); #1;
    check("done_drop", done_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    cfg_t c;
    int nb, fa, fs, la;

    rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b1; up_down_i = 1'b1;
    base_addr_i = '0; group_size_i = '0; slide_offset_i = '0; sew_i = '0; el_count_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_sub", sub_sel_o, 0);
    check("rst_last", last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(mkvec(mkcfg(2, 1, 16, 0, 0, 1, 8), 0, 8, 16, 0, 23));
    vecs.push_back(mkvec(mkcfg(0, 2, 40, 100, 0, 1, 34), 0, 34, 40, 0, 100));
    vecs.push_back(mkvec(mkcfg(2, 1, 16, 0, 0, 1, 8), 2, 8, 16, 0, 23));
    vecs.push_back(mkvec(mkcfg(2, 1, 510, 0, 5, 1, 3), 0, 3, 3, 0, 5));
    vecs.push_back(mkvec(mkcfg(2, 1, 16, 0, 0, 1, 0), 0, 0, 0, 0, 0));
    vecs.push_back(mkvec(mkcfg(3, 1, 16, 0, 0, 1, 8), 0, 0, 0, 0, 0));
    vecs.push_back(mkvec(mkcfg(2, 0, 16, 0, 0, 1, 8), 0, 0, 0, 0, 0));
    vecs.push_back(mkvec(mkcfg(2, 2, 16, 200, 0, 1, 100), 0, 16, 16, 0, 207));
    vecs.push_back(mkvec(mkcfg(1, 1, 50, 0, 0, 1, 5), 0, 5, 50, 0, 52));
    vecs.push_back(mkvec(mkcfg(2, 1, 16, 0, 0, 1, 8), 3, 8, 16, 0, 23));
`ifdef VRF_ADDR_DOWN_EN
    vecs.push_back(mkvec(mkcfg(1, 1, 16, 0, 2, 0, 16), 0, 16, 21, 2, 14));
    vecs.push_back(mkvec(mkcfg(2, 2, 40, 100, 0, 0, 16), 0, 16, 107, 0, 40));
`else
    vecs.push_back(mkvec(mkcfg(1, 1, 16, 0, 2, 0, 16), 0, 16, 18, 0, 25));
    vecs.push_back(mkvec(mkcfg(2, 2, 40, 100, 0, 0, 16), 0, 16, 40, 0, 107));
`endif

    foreach (vecs[i]) begin
      do_run(vecs[i].c, vecs[i].mode, nb, fa, fs, la);
      check("vec_beats", nb, vecs[i].exp_beats);
      if (vecs[i].exp_beats > 0) begin
        check("vec_first_addr", fa, vecs[i].exp_first_addr);
        check("vec_first_sub", fs, vecs[i].exp_first_sub);
        check("vec_last_addr", la, vecs[i].exp_last_addr);
      end
    end

    // Reset in the middle of a run, then a fresh run from beat 1.
    c = mkcfg(2, 1, 16, 0, 0, 1, 8);
    base_addr_i = c.bases; group_size_i = 4'd1; slide_offset_i = '0;
    up_down_i = 1'b1; sew_i = 2'b10; el_count_i = 9'd8; ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("mr_beat1", addr_o, 16);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mr_beat3", addr_o, 18);
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("mr_valid", valid_o, 0);
    check("mr_addr", addr_o, 0);
    check("mr_sub", sub_sel_o, 0);
    check("mr_last", last_o, 0);
    check("mr_busy", busy_o, 0);
    check("mr_done", done_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    do_run(c, 0, nb, fa, fs, la);
    check("mr_restart_first", fa, 16);
    check("mr_restart_beats", nb, 8);

    for (int i = 0; i < 40; i++) begin
      c.sew   = int'($urandom_range(0, 3));
      c.gs    = int'($urandom_range(0, 8));
      c.slide = int'($urandom_range(0, 511));
      c.up    = int'($urandom_range(0, 1));
      c.elc   = int'($urandom_range(0, 300));
      c.bases = (MG*AW)'({$urandom(), $urandom(), $urandom()});
      do_run(c, 1, nb, fa, fs, la);
      check("rand_beats", nb, model_n(c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
